// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets, FSM state
// encoding and STATUS bit positions.
package mmio_pkg;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_st_e;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  function automatic logic [31:0] pack_status(input logic ovf, input logic busy,
                                              input logic empty, input logic full);
    logic [31:0] s;
    s = '0;
    s[ST_OVF]   = ovf;
    s[ST_BUSY]  = busy;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Show-ahead synchronous FIFO with count-based flags. A push while full is only
// taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and combinational status reads.
// Define MMIO_UART_STALL_EN to stall the core on a full FIFO instead of dropping bytes.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [15:0] DIV_RST = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        wen,
  input  logic        ren,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        stall,
  output uart_st_e    dbg_state_o
);

  uart_st_e    state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        txd_q;
  logic [15:0] div_q;
  logic [15:0] div_d;
  logic        ovf_q;
  logic        ovf_d;

  logic        wr_acc;
  logic        rd_acc;
  logic        tx_wr;
  logic        fifo_push;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        bit_done;
  logic        pop_this_cycle;
  logic        ovf_set;
  logic        busy;
  logic        unused_wdata;

  assign wr_acc       = sel & wen;
  assign rd_acc       = sel & ren;
  assign tx_wr        = wr_acc & (addr == UART_TXDATA);
  assign bit_done     = (cnt_q == 16'd0);
  assign busy         = (state_q != IDLE);
  assign unused_wdata = ^wdata[31:16];

  // The FSM takes the head byte on leaving IDLE or at the end of a stop bit.
  assign pop_this_cycle = ~fifo_empty &
                          ((state_q == IDLE) | ((state_q == STOP) & bit_done));

`ifdef MMIO_UART_STALL_EN
  assign stall     = tx_wr & fifo_full & ~pop_this_cycle;
  assign fifo_push = tx_wr & ~stall;
  assign ovf_set   = 1'b0;
`else
  assign stall     = 1'b0;
  assign fifo_push = tx_wr;
  assign ovf_set   = tx_wr & fifo_full & ~pop_this_cycle;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (pop_this_cycle),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    div_d = div_q;
    if (wr_acc && (addr == UART_DIV)) begin
      div_d = wdata[15:0];
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_acc && (addr == UART_STATUS) && wdata[ST_OVF]) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_RST;
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  // Every bit (start, data, stop) lasts div_q+1 cycles; the counter reloads at each
  // bit boundary so divisor writes land cleanly on the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      txd_q     <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_this_cycle) begin
            state_q <= START;
            txd_q   <= 1'b0;
            shift_q <= fifo_dout;
            cnt_q   <= div_q;
          end
        end
        START: begin
          if (bit_done) begin
            state_q   <= DATA;
            txd_q     <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= 3'd0;
            cnt_q     <= div_q;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q <= div_q;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt_q <= div_q;
            if (pop_this_cycle) begin
              state_q <= START;
              txd_q   <= 1'b0;
              shift_q <= fifo_dout;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_acc) begin
      case (addr)
        UART_STATUS: rdata = pack_status(ovf_q, busy, fifo_empty, fifo_full);
        UART_DIV:    rdata = {16'h0000, div_q};
        default:     rdata = '0;
      endcase
    end
  end

  assign txd         = txd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx: a timing model predicts frame start cycles,
// FIFO occupancy, drops/stalls and STATUS; a txd monitor checks every frame.
module tb_mmio_uart_tx;
  import mmio_pkg::*;

  localparam int          DEPTH   = 8;
  localparam logic [15:0] DIV_RST = 16'd867;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        wen;
  logic        ren;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        txd;
  logic        stall;
  uart_st_e    dbg_state;

  mmio_uart_tx #(.DEPTH(DEPTH), .DIV_RST(DIV_RST)) dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .wen         (wen),
    .ren         (ren),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .txd         (txd),
    .stall       (stall),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc   = 0;
  logic rst_s = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted byte pushed at edge p starts its frame at max(p+1, end of previous
  // frame); the FIFO pops at that start edge. Occupancy follows from these times.
  int          acc_p[$];
  int          acc_s[$];
  int          last_end  = -1000000;
  int          frame_len = 10 * (int'(DIV_RST) + 1);
  logic [15:0] div_m     = DIV_RST;
  bit          ovf_m     = 1'b0;

  function automatic int cnt_before(input int c);
    int n = 0;
    foreach (acc_p[i]) if (acc_p[i] < c && acc_s[i] >= c) n++;
    return n;
  endfunction

  function automatic int cnt_after(input int c);
    int n = 0;
    foreach (acc_p[i]) if (acc_p[i] <= c && acc_s[i] > c) n++;
    return n;
  endfunction

  function automatic bit pop_at(input int c);
    foreach (acc_s[i]) if (acc_s[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit busy_at(input int c);
    foreach (acc_s[i]) if (acc_s[i] <= c && c < acc_s[i] + frame_len) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] status_at(input int c);
    logic [31:0] s;
    int n;
    n = cnt_after(c);
    s = {28'h0, ovf_m, busy_at(c), (n == 0), (n == DEPTH)};
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];   // {start cycle, byte}

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [7:0] b);
    int p;
    int s;
    int tries;
    bit done;
    bit full_b;
    bit pop_b;
    done  = 1'b0;
    tries = 0;
    while (!done) begin
      p      = cyc + 1;
      sel    = 1'b1;
      wen    = 1'b1;
      ren    = 1'b0;
      addr   = UART_TXDATA;
      wdata  = {24'($urandom), b};
      full_b = (cnt_before(p) == DEPTH);
      pop_b  = pop_at(p);
      #1;
`ifdef MMIO_UART_STALL_EN
      chk("stall", stall, full_b && !pop_b);
`else
      chk("stall", stall, 1'b0);
`endif
      if (!full_b || pop_b) begin
        s = (p + 1 > last_end) ? p + 1 : last_end;
        last_end = s + frame_len;
        acc_p.push_back(p);
        acc_s.push_back(s);
        exp_q.push_back({s[31:0], b});
        done = 1'b1;
      end else begin
`ifdef MMIO_UART_STALL_EN
        tries++;
        if (tries > 4000) begin
          checks++;
          errors++;
          $display("FAIL stall_timeout: store held %0d cycles, required release", tries);
          done = 1'b1;
        end
`else
        ovf_m = 1'b1;
        done  = 1'b1;
`endif
      end
      @(posedge clk);
      #1;
    end
    sel = 1'b0;
    wen = 1'b0;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    sel   = 1'b1;
    wen   = 1'b1;
    ren   = 1'b0;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    wen = 1'b0;
    if (a == UART_DIV) begin
      div_m     = d[15:0];
      frame_len = 10 * (int'(d[15:0]) + 1);
    end
    if (a == UART_STATUS && d[3]) ovf_m = 1'b0;
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [31:0] exp, input string nm);
    sel  = 1'b1;
    ren  = 1'b1;
    wen  = 1'b0;
    addr = a;
    #1;
    chk(nm, rdata, exp);
    @(posedge clk);
    #1;
    sel = 1'b0;
    ren = 1'b0;
  endtask

  task automatic drain();
    int target;
    target = last_end + 3;
    while ((cyc < target || exp_q.size() != 0 || in_frame) && cyc < target + 200) idle(1);
    chk("drain_exp_q_empty", exp_q.size(), 0);
    acc_p.delete();
    acc_s.delete();
  endtask

  // ---------------- txd monitor ----------------
  bit          mon_en = 1'b0;
  bit          in_frame = 1'b0;
  int          k;
  int          bad;
  logic [7:0]  cur_b;
  logic [7:0]  got_b;
  logic [39:0] ent;

  always @(negedge clk) begin
    int per;
    int idx;
    logic eb;
    if (!mon_en || rst_s) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && txd !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: txd=%b at cycle %0d, expected idle 1", txd, cyc);
        end else begin
          ent = exp_q.pop_front();
          chk("frame_start_cycle", cyc, ent[39:8]);
          cur_b    = ent[7:0];
          got_b    = '0;
          bad      = 0;
          k        = 0;
          in_frame = 1'b1;
        end
      end
      if (in_frame) begin
        per = frame_len / 10;
        idx = k / per;
        if (idx == 0) eb = 1'b0;
        else if (idx == 9) eb = 1'b1;
        else eb = cur_b[idx-1];
        if (txd !== eb) bad++;
        if (idx >= 1 && idx <= 8 && (k % per) == per / 2) got_b[idx-1] = txd;
        k++;
        if (k == frame_len) begin
          chk("frame_bad_cycles", bad, 0);
          chk("frame_byte", got_b, cur_b);
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    int guard;
    logic [15:0] d;
    int op;
    rst   = 1'b1;
    sel   = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset state and idle line.
    for (int i = 0; i < 20; i++) begin
      chk("idle_txd", txd, 1'b1);
      chk("idle_stall", stall, 1'b0);
      idle(1);
    end
    read_chk(UART_STATUS, status_at(cyc), "reset_status");
    read_chk(UART_DIV, {16'h0, div_m}, "reset_div");
    write_reg(UART_DIV, 32'hABCD_0003);
    read_chk(UART_DIV, {16'h0, div_m}, "div_readback");

    // Register map corners.
    write_reg(4'hC, 32'h0000_0007);
    read_chk(UART_DIV, {16'h0, div_m}, "unmapped_write_ignored");
    read_chk(4'hC, 32'h0, "unmapped_read");
    read_chk(UART_TXDATA, 32'h0, "txdata_read");
    sel = 1'b1; ren = 1'b0; addr = UART_STATUS; #1;
    chk("rdata_no_ren", rdata, 32'h0);
    sel = 1'b0; ren = 1'b1; #1;
    chk("rdata_no_sel", rdata, 32'h0);
    ren = 1'b0;
    idle(1);

    // Single frame, busy window polled every cycle.
    store(8'hA5);
    for (int i = 0; i < 44; i++) read_chk(UART_STATUS, status_at(cyc), "status_frame");
    drain();

    // Back-to-back frames.
    store(8'h55);
    store(8'h0F);
    for (int i = 0; i < 86; i++) read_chk(UART_STATUS, status_at(cyc), "status_b2b");
    drain();

    // Overflow (or stall) with a frame already on the line.
    store(8'h11);
    idle(3);
    for (int i = 0; i < 10; i++) store(8'(8'h20 + i));
    read_chk(UART_STATUS, status_at(cyc), "status_after_burst");
    write_reg(UART_STATUS, 32'h8);
    read_chk(UART_STATUS, status_at(cyc), "status_ovf_cleared");
    drain();

    // Reset in the middle of data bit 3.
    store(8'hC3);
    s0 = last_end - frame_len;
    guard = 0;
    while (cyc < s0 + 18 && guard < 100) begin
      idle(1);
      guard++;
    end
    chk("state_mid_data", dbg_state, DATA);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_p.delete();
    acc_s.delete();
    last_end  = -1000000;
    ovf_m     = 1'b0;
    div_m     = DIV_RST;
    frame_len = 10 * (int'(DIV_RST) + 1);
    chk("rst_txd", txd, 1'b1);
    read_chk(UART_STATUS, status_at(cyc), "rst_status");
    read_chk(UART_DIV, {16'h0, div_m}, "rst_div");
    write_reg(UART_DIV, 32'h3);
    store(8'h3C);
    drain();

    // Randomized traffic with varying divisors.
    for (int r = 0; r < 3; r++) begin
      d = 16'($urandom_range(1, 4));
      write_reg(UART_DIV, {16'h0, d});
      for (int i = 0; i < 30; i++) begin
        op = $urandom_range(0, 9);
        if (op < 6) store(8'($urandom));
        else if (op < 9) idle($urandom_range(0, 8));
        else read_chk(UART_STATUS, status_at(cyc), "status_rand");
      end
      read_chk(UART_STATUS, status_at(cyc), "status_rand_end");
      if (ovf_m) write_reg(UART_STATUS, 32'h8);
      drain();
    end

    chk("final_exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
